// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_pkg
// Brief    : Opcodes, funct codes, ALU op enum and decode/pipeline structs
//            shared by the decode stage and its decoder.
// Revision : 1.0 - initial release
// ============================================================================
package mips_pkg;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes
  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_SLT  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_LUI  = 4'd6,
    ALU_PASS = 4'd7
  } alu_op_t;

  // Decoded control; reads_rt is internal and only feeds hazard detection
  typedef struct packed {
    logic    illegal;
    logic    wr_en;
    logic    mem_rd;
    logic    mem_wr;
    logic    use_imm;
    logic    beq;
    logic    bne;
    logic    reads_rt;
    alu_op_t alu_op;
  } ctrl_t;

  localparam ctrl_t NOP_CTRL = '{
    illegal:  1'b0,
    wr_en:    1'b0,
    mem_rd:   1'b0,
    mem_wr:   1'b0,
    use_imm:  1'b0,
    beq:      1'b0,
    bne:      1'b0,
    reads_rt: 1'b0,
    alu_op:   ALU_ADD
  };

  // ID/EX pipeline register contents
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    ctrl_t       ctrl;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] imm;
    logic [4:0]  shamt;
    logic [4:0]  rs_num;
    logic [4:0]  rt_num;
    logic [4:0]  dest;
  } idex_t;

endpackage
`default_nettype wire

// File: rtl/instr_decoder.sv
`default_nettype none
// ============================================================================
// Module   : instr_decoder
// Brief    : Combinational decode of the supported MIPS subset into control
//            flags, ALU op, destination register and extended immediate.
// Revision : 1.0 - initial release
// ============================================================================
module instr_decoder
  import mips_pkg::*;
(
  input  logic [31:0] instr_i,
  output ctrl_t       ctrl_o,
  output logic [4:0]  dest_o,
  output logic [31:0] imm_o
);

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [31:0] imm_sx;
  logic [31:0] imm_zx;
  ctrl_t       ctrl_raw;

  assign opcode = instr_i[31:26];
  assign funct  = instr_i[5:0];
  assign rt     = instr_i[20:16];
  assign rd     = instr_i[15:11];
  assign imm_sx = {{16{instr_i[15]}}, instr_i[15:0]};
  assign imm_zx = {16'h0000, instr_i[15:0]};

  // Opcode/funct table; unknown encodings raise only the illegal flag
  always_comb begin
    ctrl_raw = NOP_CTRL;
    dest_o   = 5'd0;
    imm_o    = 32'h0;
    unique case (opcode)
      OP_RTYPE: begin
        ctrl_raw.wr_en    = 1'b1;
        ctrl_raw.reads_rt = 1'b1;
        dest_o            = rd;
        case (funct)
          FN_ADD:  ctrl_raw.alu_op = ALU_ADD;
          FN_SUB:  ctrl_raw.alu_op = ALU_SUB;
          FN_AND:  ctrl_raw.alu_op = ALU_AND;
          FN_OR:   ctrl_raw.alu_op = ALU_OR;
          FN_SLT:  ctrl_raw.alu_op = ALU_SLT;
          FN_SLL:  ctrl_raw.alu_op = ALU_SLL;
          default: begin
            ctrl_raw         = NOP_CTRL;
            ctrl_raw.illegal = 1'b1;
            dest_o           = 5'd0;
          end
        endcase
      end
      OP_ADDI: begin
        ctrl_raw.wr_en   = 1'b1;
        ctrl_raw.use_imm = 1'b1;
        ctrl_raw.alu_op  = ALU_ADD;
        dest_o           = rt;
        imm_o            = imm_sx;
      end
      OP_ANDI: begin
        ctrl_raw.wr_en   = 1'b1;
        ctrl_raw.use_imm = 1'b1;
        ctrl_raw.alu_op  = ALU_AND;
        dest_o           = rt;
        imm_o            = imm_zx;
      end
      OP_ORI: begin
        ctrl_raw.wr_en   = 1'b1;
        ctrl_raw.use_imm = 1'b1;
        ctrl_raw.alu_op  = ALU_OR;
        dest_o           = rt;
        imm_o            = imm_zx;
      end
      OP_LUI: begin
        ctrl_raw.wr_en   = 1'b1;
        ctrl_raw.use_imm = 1'b1;
        ctrl_raw.alu_op  = ALU_LUI;
        dest_o           = rt;
        imm_o            = {instr_i[15:0], 16'h0000};
      end
      OP_LW: begin
        ctrl_raw.wr_en   = 1'b1;
        ctrl_raw.mem_rd  = 1'b1;
        ctrl_raw.use_imm = 1'b1;
        ctrl_raw.alu_op  = ALU_ADD;
        dest_o           = rt;
        imm_o            = imm_sx;
      end
      OP_SW: begin
        ctrl_raw.mem_wr   = 1'b1;
        ctrl_raw.use_imm  = 1'b1;
        ctrl_raw.reads_rt = 1'b1;
        ctrl_raw.alu_op   = ALU_ADD;
        imm_o             = imm_sx;
      end
      OP_BEQ: begin
        ctrl_raw.beq      = 1'b1;
        ctrl_raw.reads_rt = 1'b1;
        ctrl_raw.alu_op   = ALU_SUB;
        imm_o             = imm_sx;
      end
      OP_BNE: begin
        ctrl_raw.bne      = 1'b1;
        ctrl_raw.reads_rt = 1'b1;
        ctrl_raw.alu_op   = ALU_SUB;
        imm_o             = imm_sx;
      end
      default: ctrl_raw.illegal = 1'b1;
    endcase
  end

  // A write to r0 is architecturally a no-op, so drop the enable here
  always_comb begin
    ctrl_o       = ctrl_raw;
    ctrl_o.wr_en = ctrl_raw.wr_en && (dest_o != 5'd0);
  end

endmodule
`default_nettype wire

// File: rtl/id_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_stage
// Brief    : Decode stage: register read with writeback bypass, load-use
//            hazard detection and the ID/EX pipeline register.
// Revision : 1.0 - initial release
// ============================================================================
module id_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] NOP_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_valid,
  input  logic [31:0] if_instr,
  input  logic [31:0] if_pc,
  output logic        id_stall,
  output logic [4:0]  rf_rd0_num,
  input  logic [31:0] rf_rd0_data,
  output logic [4:0]  rf_rd1_num,
  input  logic [31:0] rf_rd1_data,
  input  logic        wb_wr_en,
  input  logic [4:0]  wb_wr_num,
  input  logic [31:0] wb_wr_data,
  input  logic        ex_flush,
  output logic        ex_valid,
  output logic [31:0] ex_pc,
  output alu_op_t     ex_alu_op,
  output logic [31:0] ex_rs_val,
  output logic [31:0] ex_rt_val,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_shamt,
  output logic [4:0]  ex_rs_num,
  output logic [4:0]  ex_rt_num,
  output logic [4:0]  ex_dest,
  output logic        ex_wr_en,
  output logic        ex_mem_rd,
  output logic        ex_mem_wr,
  output logic        ex_use_imm,
  output logic        ex_beq,
  output logic        ex_bne,
  output logic        ex_illegal
);

  ctrl_t       dec_ctrl;
  logic [4:0]  dec_dest;
  logic [31:0] dec_imm;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        hz;
  idex_t       idex_d;
  idex_t       idex_q;
  idex_t       bubble;

  instr_decoder u_dec (
    .instr_i (if_instr),
    .ctrl_o  (dec_ctrl),
    .dest_o  (dec_dest),
    .imm_o   (dec_imm)
  );

  assign rf_rd0_num = if_instr[25:21];
  assign rf_rd1_num = if_instr[20:16];

  // Operand select: r0 is hard zero, else prefer the write landing this edge
  always_comb begin
    if (rf_rd0_num == 5'd0)
      rs_val = 32'h0;
    else if (wb_wr_en && (wb_wr_num == rf_rd0_num))
      rs_val = wb_wr_data;
    else
      rs_val = rf_rd0_data;
    if (rf_rd1_num == 5'd0)
      rt_val = 32'h0;
    else if (wb_wr_en && (wb_wr_num == rf_rd1_num))
      rt_val = wb_wr_data;
    else
      rt_val = rf_rd1_data;
  end

  // Load in EX whose result the instruction in decode needs right now
  always_comb begin
    hz = idex_q.valid && idex_q.ctrl.mem_rd && (idex_q.dest != 5'd0) &&
         if_valid &&
         ((idex_q.dest == rf_rd0_num) ||
          (dec_ctrl.reads_rt && (idex_q.dest == rf_rd1_num)));
  end

  assign id_stall = hz && !ex_flush;

  // Next ID/EX contents: bubble on flush or hazard, else the fresh decode
  always_comb begin
    bubble      = '0;
    bubble.pc   = NOP_PC;
    bubble.ctrl = NOP_CTRL;
    if (ex_flush || hz) begin
      idex_d = bubble;
    end else begin
      idex_d.valid  = if_valid;
      idex_d.pc     = if_pc;
      idex_d.ctrl   = dec_ctrl;
      idex_d.rs_val = rs_val;
      idex_d.rt_val = rt_val;
      idex_d.imm    = dec_imm;
      idex_d.shamt  = if_instr[10:6];
      idex_d.rs_num = rf_rd0_num;
      idex_d.rt_num = rf_rd1_num;
      idex_d.dest   = dec_dest;
    end
  end

  // ID/EX pipeline register
  always_ff @(posedge clk) begin
    if (reset) idex_q <= bubble;
    else       idex_q <= idex_d;
  end

  assign ex_valid   = idex_q.valid;
  assign ex_pc      = idex_q.pc;
  assign ex_alu_op  = idex_q.ctrl.alu_op;
  assign ex_rs_val  = idex_q.rs_val;
  assign ex_rt_val  = idex_q.rt_val;
  assign ex_imm     = idex_q.imm;
  assign ex_shamt   = idex_q.shamt;
  assign ex_rs_num  = idex_q.rs_num;
  assign ex_rt_num  = idex_q.rt_num;
  assign ex_dest    = idex_q.dest;
  assign ex_wr_en   = idex_q.ctrl.wr_en;
  assign ex_mem_rd  = idex_q.ctrl.mem_rd;
  assign ex_mem_wr  = idex_q.ctrl.mem_wr;
  assign ex_use_imm = idex_q.ctrl.use_imm;
  assign ex_beq     = idex_q.ctrl.beq;
  assign ex_bne     = idex_q.ctrl.bne;
  assign ex_illegal = idex_q.ctrl.illegal;

endmodule
`default_nettype wire

// File: tb/tb_id_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_stage
// Brief    : Directed self-checking bench for id_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_stage;
  import mips_pkg::*;

  localparam logic [31:0] C_NOP_PC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_stall;
  logic [4:0]  rf_rd0_num;
  logic [31:0] rf_rd0_data;
  logic [4:0]  rf_rd1_num;
  logic [31:0] rf_rd1_data;
  logic        wb_wr_en;
  logic [4:0]  wb_wr_num;
  logic [31:0] wb_wr_data;
  logic        ex_flush;
  logic        ex_valid;
  logic [31:0] ex_pc;
  alu_op_t     ex_alu_op;
  logic [31:0] ex_rs_val;
  logic [31:0] ex_rt_val;
  logic [31:0] ex_imm;
  logic [4:0]  ex_shamt;
  logic [4:0]  ex_rs_num;
  logic [4:0]  ex_rt_num;
  logic [4:0]  ex_dest;
  logic        ex_wr_en;
  logic        ex_mem_rd;
  logic        ex_mem_wr;
  logic        ex_use_imm;
  logic        ex_beq;
  logic        ex_bne;
  logic        ex_illegal;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  id_stage #(.NOP_PC(C_NOP_PC)) dut (
    .clk         (clk),
    .reset       (reset),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .id_stall    (id_stall),
    .rf_rd0_num  (rf_rd0_num),
    .rf_rd0_data (rf_rd0_data),
    .rf_rd1_num  (rf_rd1_num),
    .rf_rd1_data (rf_rd1_data),
    .wb_wr_en    (wb_wr_en),
    .wb_wr_num   (wb_wr_num),
    .wb_wr_data  (wb_wr_data),
    .ex_flush    (ex_flush),
    .ex_valid    (ex_valid),
    .ex_pc       (ex_pc),
    .ex_alu_op   (ex_alu_op),
    .ex_rs_val   (ex_rs_val),
    .ex_rt_val   (ex_rt_val),
    .ex_imm      (ex_imm),
    .ex_shamt    (ex_shamt),
    .ex_rs_num   (ex_rs_num),
    .ex_rt_num   (ex_rt_num),
    .ex_dest     (ex_dest),
    .ex_wr_en    (ex_wr_en),
    .ex_mem_rd   (ex_mem_rd),
    .ex_mem_wr   (ex_mem_wr),
    .ex_use_imm  (ex_use_imm),
    .ex_beq      (ex_beq),
    .ex_bne      (ex_bne),
    .ex_illegal  (ex_illegal)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present an instruction just after a rising edge
  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
    if_valid = v;
    if_instr = ins;
    if_pc    = pc;
  endtask

  // Advance to 1 time unit after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; ex_flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    rf_rd0_data = 32'h0; rf_rd1_data = 32'h0;
    wb_wr_en = 1'b0; wb_wr_num = 5'd0; wb_wr_data = 32'h0;
    step(); step();

    check("rst_valid",  {31'b0, ex_valid},   32'd0);
    check("rst_pc",     ex_pc,               C_NOP_PC);
    check("rst_stall",  {31'b0, id_stall},   32'd0);
    check("rst_imm",    ex_imm,              32'd0);
    check("rst_dest",   {27'b0, ex_dest},    32'd0);
    check("rst_wr_en",  {31'b0, ex_wr_en},   32'd0);
    check("rst_rs_val", ex_rs_val,           32'd0);
    reset = 1'b0;

    // ADDI r5,r0,-4
    drive(1'b1, 32'h2005FFFC, 32'h0000_0010);
    step();
    check("addi_valid", {31'b0, ex_valid},   32'd1);
    check("addi_pc",    ex_pc,               32'h0000_0010);
    check("addi_imm",   ex_imm,              32'hFFFFFFFC);
    check("addi_dest",  {27'b0, ex_dest},    32'd5);
    check("addi_wr_en", {31'b0, ex_wr_en},   32'd1);
    check("addi_useim", {31'b0, ex_use_imm}, 32'd1);
    check("addi_aluop", {28'b0, ex_alu_op},  32'd0);

    // ADD r3,r1,r2 with writeback to r1 in the same cycle
    drive(1'b1, 32'h00221820, 32'h0000_0014);
    rf_rd0_data = 32'd7; rf_rd1_data = 32'd9;
    wb_wr_en = 1'b1; wb_wr_num = 5'd1; wb_wr_data = 32'h55;
    #1;
    check("add_rd0num", {27'b0, rf_rd0_num}, 32'd1);
    check("add_rd1num", {27'b0, rf_rd1_num}, 32'd2);
    step();
    check("byp_rs_val", ex_rs_val,           32'h55);
    check("byp_rt_val", ex_rt_val,           32'd9);
    check("add_dest",   {27'b0, ex_dest},    32'd3);
    check("add_useimm", {31'b0, ex_use_imm}, 32'd0);

    // Same ADD, writeback targets r0: bypass must be ignored
    wb_wr_num = 5'd0;
    step();
    check("nobyp_rs",   ex_rs_val,           32'd7);
    wb_wr_en = 1'b0;

    // LW r4,0(r1) then ADD r6,r4,r4 -> one-cycle stall
    drive(1'b1, 32'h8C240000, 32'h0000_0020);
    step();
    check("lw_mem_rd",  {31'b0, ex_mem_rd},  32'd1);
    check("lw_dest",    {27'b0, ex_dest},    32'd4);
    drive(1'b1, 32'h00843020, 32'h0000_0024);
    #1;
    check("lu_stall",   {31'b0, id_stall},   32'd1);
    step();
    check("lu_bubble",  {31'b0, ex_valid},   32'd0);
    check("lu_bub_pc",  ex_pc,               C_NOP_PC);
    check("lu_stall2",  {31'b0, id_stall},   32'd0);
    step();
    check("lu_issue",   {31'b0, ex_valid},   32'd1);
    check("lu_rs_num",  {27'b0, ex_rs_num},  32'd4);
    check("lu_dest",    {27'b0, ex_dest},    32'd6);

    // Load-use pair with flush in the stall cycle
    drive(1'b1, 32'h8C240000, 32'h0000_0030);
    step();
    drive(1'b1, 32'h00843020, 32'h0000_0034);
    ex_flush = 1'b1;
    #1;
    check("fl_stall",   {31'b0, id_stall},   32'd0);
    step();
    check("fl_valid",   {31'b0, ex_valid},   32'd0);
    ex_flush = 1'b0;

    // LW r4 then ADDI r4,r1,1: rt is a destination, no hazard
    drive(1'b1, 32'h8C240000, 32'h0000_0040);
    step();
    drive(1'b1, 32'h20240001, 32'h0000_0044);
    #1;
    check("addi_nohz",  {31'b0, id_stall},   32'd0);
    step();
    check("addi_issue", {31'b0, ex_valid},   32'd1);

    // LW r4 then invalid slot holding a consumer: no stall
    drive(1'b1, 32'h8C240000, 32'h0000_0050);
    step();
    drive(1'b0, 32'h00843020, 32'h0000_0054);
    #1;
    check("inv_nostall", {31'b0, id_stall},  32'd0);
    step();
    check("inv_valid",  {31'b0, ex_valid},   32'd0);

    // Reset asserted during a stall
    drive(1'b1, 32'h8C240000, 32'h0000_0060);
    step();
    drive(1'b1, 32'h00843020, 32'h0000_0064);
    reset = 1'b1;
    step();
    check("rs_stall",   {31'b0, id_stall},   32'd0);
    check("rs_memrd",   {31'b0, ex_mem_rd},  32'd0);
    check("rs_pc",      ex_pc,               C_NOP_PC);
    reset = 1'b0;

    // Unknown opcode 0x3F
    drive(1'b1, 32'hFC000000, 32'h0000_0070);
    step();
    check("ill_flag",   {31'b0, ex_illegal}, 32'd1);
    check("ill_wr_en",  {31'b0, ex_wr_en},   32'd0);
    check("ill_valid",  {31'b0, ex_valid},   32'd1);

    // ORI r2,r0,0x8000: zero extension
    drive(1'b1, 32'h34028000, 32'h0000_0074);
    step();
    check("ori_imm",    ex_imm,              32'h00008000);
    check("ori_dest",   {27'b0, ex_dest},    32'd2);
    check("ori_ill",    {31'b0, ex_illegal}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
